// File: rtl/ps2_script_typer.sv
// ps2_script_typer
// Plays a ROM script of set-2 make scancodes as PS/2 device-to-host frames.
// Each key is sent as make, F0, make. A 0x00 entry, or the last ROM address,
// ends the script.
//   clk          system clock
//   reset        synchronous, active-high
//   start        one-cycle pulse, begins playback at entry 0 (ignored while busy)
//   script_addr  ROM address
//   script_data  ROM data, valid one cycle after script_addr changes
//   ps2clk       emulated PS/2 clock (idle high)
//   ps2data      emulated PS/2 data (idle high)
//   busy         high from start acceptance until playback ends
//   done         one-cycle pulse when the script ends, coincident with busy falling
module ps2_script_typer #(
  parameter int clk_mhz     = 25,
  parameter int ps2_khz     = 12,
  parameter int half_cycles = clk_mhz * 1000 / (2 * ps2_khz),
  parameter int byte_gap    = 8 * half_cycles,
  parameter int key_gap     = clk_mhz * 100000,
  parameter int addr_bits   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [addr_bits-1:0] script_addr,
  input  logic [7:0]           script_data,
  output logic                 ps2clk,
  output logic                 ps2data,
  output logic                 busy,
  output logic                 done
);

  localparam int HC_W  = $clog2(half_cycles) + 1;
  localparam int BG_W  = $clog2(byte_gap) + 1;
  localparam int KG_W  = $clog2(key_gap) + 1;
  localparam int GAP_W = (KG_W > BG_W) ? KG_W : BG_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_FRAME,
    ST_GAP,
    ST_FINISH
  } state_t;

  state_t           state;
  logic [HC_W-1:0]  half_cnt;
  logic [3:0]       bit_cnt;
  logic [10:0]      shreg;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       key;
  logic [1:0]       phase;     // 0: make, 1: F0, 2: repeated make
  logic             last_key;  // last ROM address already typed

  // stop, odd parity, data LSB first, start
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Frame loads happen on the transition edge itself so the start bit is on
  // the wire in the first cycle of FRAME; gap reloads subtract the cycles the
  // following states spend before that load, keeping line-idle times exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      script_addr <= '0;
      ps2clk      <= 1'b1;
      ps2data     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '1;
      gap_cnt     <= '0;
      key         <= '0;
      phase       <= '0;
      last_key    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            script_addr <= '0;
            busy        <= 1'b1;
            last_key    <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (script_data == 8'h00 || last_key) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FINISH;
          end else begin
            key      <= script_data;
            phase    <= 2'd0;
            shreg    <= frame_of(script_data);
            ps2data  <= 1'b0;
            ps2clk   <= 1'b1;
            half_cnt <= HC_W'(half_cycles - 1);
            bit_cnt  <= '0;
            state    <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - 1'b1;
          end else begin
            half_cnt <= HC_W'(half_cycles - 1);
            if (ps2clk) begin
              ps2clk <= 1'b0;
            end else if (bit_cnt == 4'd10) begin
              ps2clk  <= 1'b1;
              ps2data <= 1'b1;
              gap_cnt <= (phase == 2'd2) ? GAP_W'(key_gap - 3) : GAP_W'(byte_gap - 1);
              state   <= ST_GAP;
            end else begin
              ps2clk  <= 1'b1;
              ps2data <= shreg[1];
              shreg   <= {1'b1, shreg[10:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (phase == 2'd2) begin
            phase <= 2'd0;
            if (script_addr == '1) last_key <= 1'b1;
            else                   script_addr <= script_addr + 1'b1;
            state <= ST_FETCH;
          end else begin
            phase    <= phase + 2'd1;
            shreg    <= frame_of((phase == 2'd0) ? 8'hF0 : key);
            ps2data  <= 1'b0;
            ps2clk   <= 1'b1;
            half_cnt <= HC_W'(half_cycles - 1);
            bit_cnt  <= '0;
            state    <= ST_FRAME;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
